// File: rtl/pako32_pkg.sv
// Shared fetch types: reset PC default, fetch-buffer entry and fetch FSM states.
package pako32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetch-buffer slot; fault marks a misaligned-target marker, not an instruction
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO of fetch entries with flush, push/pop and occupancy count.
module fetch_fifo
    import pako32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               data_i,
    output fetch_entry_t               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_idx;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // A push that coincides with a flush lands in slot 0 of the emptied buffer
    assign wr_idx = flush_i ? '0 : wr_ptr;

    // Entry storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (push_i) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    // Pointers and occupancy; flush wins over a concurrent pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= push_i ? ptr_next('0) : '0;
            count  <= push_i ? CW'(1) : '0;
        end else begin
            if (push_i) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr];
    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign count_o = count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one-cycle-latency memory, prefetch buffer, redirect handling.
// Optional feature: define INSTR_FETCH_MISALIGN_CHECK_EN to report misaligned redirect
// targets as a fault entry and halt fetch until the next aligned redirect.
module instr_fetch
    import pako32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fault_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    fetch_state_t  state;
    fetch_state_t  next_state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   target;
    logic          inflight;
    logic          misalign;
    logic          deq;
    logic          issue;
    logic          push;
    logic          pop;
    logic          flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] limit;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Redirect target qualification
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign target   = redirect_pc_i;
    assign misalign = |redirect_pc_i[1:0];
`else
    assign target   = redirect_pc_i & ~32'h3;
    assign misalign = 1'b0;
`endif

    // Issue only if the word can still find a slot after this cycle's dequeue
    assign deq       = instr_valid_o & instr_ready_i;
    assign occupancy = OW'(fifo_count) + OW'(inflight);
    assign limit     = OW'(FIFO_DEPTH) + OW'(deq);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and buffer control; redirect overrides issue, push and dequeue
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        push_entry = '{pc: req_pc, instr: imem_data_i, fault: 1'b0};
        if (redirect_i) begin
            flush = 1'b1;
            if (misalign) begin
                push       = 1'b1;
                push_entry = '{pc: target, instr: '0, fault: 1'b1};
                next_state = HALT;
            end else begin
                next_state = RUN;
            end
        end else begin
            pop   = deq;
            push  = inflight & (~fifo_full | deq);
            issue = (state == RUN) && (occupancy < limit);
        end
    end

    // Fetch address and in-flight request tracking; redirect squashes the pending word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc <= target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (push_entry),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Only the misalign path ever stores fault=1, so without it fault_o is constant 0
    assign imem_pc_o     = fetch_pc;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign fault_o       = head.fault;
    assign instr_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized ready/redirect
// traffic checked against an address-order delivery model.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_data_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        fault_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    bit          exp_fault;
    bit          exp_none;
    int          gap;

    always #5 clk_i = ~clk_i;

    instr_fetch dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_pc_o     (imem_pc_o),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .fault_o       (fault_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    // Memory contents: word at 0 is a NOP, every other address gets a distinct word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous-read memory: data for the address of this cycle appears next cycle
    always @(posedge clk_i) imem_data_i <= mem_word(imem_pc_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0;
        exp_fault = 1'b0;
        exp_none  = 1'b0;
        gap       = 0;
    endtask

    // Called at a negedge: check the presented entry, drive inputs, advance the model
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic hs;
        logic mis;
        if (exp_none) begin
            check("halt_quiet", 32'(instr_valid_o), 32'd0);
        end else begin
            if (!instr_valid_o) gap++;
            else gap = 0;
            check("liveness", 32'(gap <= 2), 32'd1);
            if (instr_valid_o) begin
                check("entry_pc", instr_pc_o, exp_pc);
                check("entry_fault", 32'(fault_o), 32'(exp_fault));
                check("entry_instr", instr_o, exp_fault ? 32'h0 : mem_word(exp_pc));
            end
        end
        hs  = instr_valid_o & rdy;
        mis = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        mis = (tgt[1:0] != 2'b00);
`endif
        if (redir) begin
            gap       = 0;
            exp_none  = 1'b0;
            exp_fault = mis;
            exp_pc    = mis ? tgt : (tgt & ~32'h3);
        end else if (hs) begin
            if (exp_fault) begin
                exp_fault = 1'b0;
                exp_none  = 1'b1;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_imem_pc", imem_pc_o, 32'h0);

        // Release with decode stalled: first entry after two edges, then fill and stop
        rst_ni = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("first_issue_pc", imem_pc_o, 32'h4);
        check("lat1_valid", 32'(instr_valid_o), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("lat2_valid", 32'(instr_valid_o), 32'd1);
        check("lat2_instr", instr_o, 32'h0000_0013);
        check("lat2_pc", instr_pc_o, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        check("stall_imem_pc", imem_pc_o, 32'h8);
        check("stall_head_pc", instr_pc_o, 32'h0);

        // Ready held: one entry per cycle, consecutive addresses
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(instr_valid_o), 32'd1);
            check("stream_pc", instr_pc_o, 32'(i * 4));
            cycle(1'b1, 1'b0, 32'h0);
        end

        // Redirect while the buffer is full
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        check("redir_flush_valid", 32'(instr_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("redir_valid", 32'(instr_valid_o), 32'd1);
        check("redir_pc", instr_pc_o, 32'h100);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);

        // Misaligned redirect target
        cycle(1'b1, 1'b1, 32'h102);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        check("mis_valid", 32'(instr_valid_o), 32'd1);
        check("mis_fault", 32'(fault_o), 32'd1);
        check("mis_pc", instr_pc_o, 32'h102);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        check("halt_imem_pc", imem_pc_o, 32'h102);
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("resume_valid", 32'(instr_valid_o), 32'd1);
        check("resume_pc", instr_pc_o, 32'h200);
`else
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("mask_valid", 32'(instr_valid_o), 32'd1);
        check("mask_pc", instr_pc_o, 32'h100);
        check("mask_fault", 32'(fault_o), 32'd0);
`endif
        repeat (2) cycle(1'b1, 1'b0, 32'h0);

        // Address wrap at the top of memory
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        check("wrap_target", imem_pc_o, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        check("wrap_next_issue", imem_pc_o, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("wrap_head0", instr_pc_o, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        check("wrap_head1", instr_pc_o, 32'h0);

        // Randomized ready and aligned redirects
        for (int n = 0; n < 400; n++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] t;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            t   = $urandom;
            if ($urandom_range(0, 4) == 0) t = 32'hFFFF_FFF4 | (t & 32'h3);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            t = t & ~32'h3;
`endif
            cycle(rdy, rd, t);
        end

        // Reset in the middle of a stream
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        check("pre_reset_valid", 32'(instr_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_instr", instr_o, 32'h0);
        check("midrst_pc", instr_pc_o, 32'h0);
        check("midrst_imem_pc", imem_pc_o, 32'h0);
        redirect_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0);
        check("rerun_lat1_valid", 32'(instr_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("rerun_valid", 32'(instr_valid_o), 32'd1);
        check("rerun_pc", instr_pc_o, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 2, which is the number of fetch-buffer entries (minimum 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_pc_o, output, 32 bits: byte address presented to instruction memory.
REQ-006 The block SHALL have port imem_data_i, input, 32 bits: memory read data, valid one cycle after the address.
REQ-007 The block SHALL have port instr_o, output, 32 bits: instruction word delivered to decode.
REQ-008 The block SHALL have port instr_pc_o, output, 32 bits: address of instr_o.
REQ-009 The block SHALL have port instr_valid_o, output, 1 bit: instr_o, instr_pc_o and fault_o are valid.
REQ-010 The block SHALL have port instr_ready_i, input, 1 bit: decode accepts the entry.
REQ-011 The block SHALL have port fault_o, output, 1 bit: the entry is a misaligned-target fault, not an instruction.
REQ-012 The block SHALL have port redirect_i, input, 1 bit: redirect fetch (branch or jump).
REQ-013 The block SHALL have port redirect_pc_i, input, 32 bits: redirect target address.

Function
REQ-014 imem_pc_o SHALL always equal the fetch_pc register.
- Memory has no enable, so a stall holds fetch_pc and the repeated read data is ignored.
REQ-015 A request SHALL be issued in a cycle when count + inflight - deq < FIFO_DEPTH.
- deq = instr_valid_o & instr_ready_i.
- On issue: fetch_pc += 4 (wraps modulo 2^32), inflight set, req_pc captured.
REQ-016 When inflight is set, the next cycle SHALL push {req_pc, imem_data_i, fault=0} into the FIFO.
- Push and pop in the same cycle are legal; count remains unchanged.
REQ-017 Output fields SHALL come from the registered FIFO head.
- First instr_valid_o appears 2 cycles after the issue cycle.
- Sustained throughput with instr_ready_i held 1: one instruction per cycle.
REQ-018 Entries SHALL be delivered strictly in address order with no loss or duplication.
- The head and all outputs stay stable while instr_valid_o=1 and instr_ready_i=0.
REQ-019 redirect_i=1 SHALL flush the FIFO, squash inflight (the next imem_data_i is discarded), and load fetch_pc with the target.
- The first issue to the target occurs in the following cycle.
- Redirect has priority over issue, push and deq.
REQ-020 A handshake coinciding with redirect_i SHALL count as completed.
- Decode is responsible for discarding the instruction.
REQ-021 States SHALL be RUN and HALT.
- RUN to HALT on a faulting redirect.
- HALT to RUN only on a non-faulting redirect.
- In HALT no issue occurs and fetch_pc holds.

Reset
REQ-022 While rst_ni=0, the block SHALL drive fetch_pc=RESET_PC, count=0, inflight=0, state=RUN, instr_valid_o=0, fault_o=0, instr_o=0, instr_pc_o=0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately.
- The first issue after deassertion is RESET_PC, in the first clock edge after release.

Configuration
REQ-024 With macro INSTR_FETCH_MISALIGN_CHECK_EN defined, a redirect target with [1:0]!=0 SHALL flush, push a single entry {pc=target, instr=0, fault=1}, and enter HALT.
REQ-025 Without INSTR_FETCH_MISALIGN_CHECK_EN, target bits [1:0] SHALL be forced to 0, fault_o SHALL be tied to 0, and HALT SHALL be unreachable.

Structure
REQ-026 Package pako32_pkg SHALL hold the RESET_PC default constant and a fetch_entry_t struct {pc[31:0], instr[31:0], fault}.
REQ-027 The buffer SHALL be a sub-module fetch_fifo with push/pop/flush, full/empty, and a count output.

Verification
REQ-028 Reset release with memory word at address 0 = 32'h0000_0013 SHALL produce instr_valid_o=1 on the 2nd edge after release, with instr_o=32'h13 and instr_pc_o=0.
REQ-029 instr_ready_i held 1 for 8 cycles SHALL yield instr_pc_o 0,4,8,...,28 on consecutive cycles with no gaps.
REQ-030 instr_ready_i=0 for 5 cycles then 1 SHALL cause imem_pc_o to stop advancing after the FIFO fills (count=2), then resume with no lost or duplicated pcs.
REQ-031 redirect_i=1 with redirect_pc_i=32'h100 while the FIFO is full SHALL make instr_valid_o=0 the next cycle and the next delivered entry instr_pc_o=32'h100.
REQ-032 With INSTR_FETCH_MISALIGN_CHECK_EN defined, redirect to 32'h102 SHALL produce one entry {fault_o=1, instr_pc_o=32'h102}, then no valid until a redirect to 32'h200 resumes at 32'h200.
REQ-033 Fetch from 32'hFFFF_FFFC SHALL make the next issued pc 32'h0000_0000.
REQ-034 rst_ni asserted mid-stream SHALL clear instr_valid_o immediately.
